// File: rtl/mem_responder.sv
// mem_responder: in-order request queue feeding a fixed-latency 64-bit word memory.
// Requests are queued and then served one at a time. Each request waits LATENCY
// cycles before its access, and its response is held until the consumer takes it.
// Optional feature: define MEM_RESPONDER_BOUNDS_CHECK_EN to flag word indices >= DEPTH
// as errors. When it is not defined, the upper address bits are ignored and the index wraps.
//
// state | meaning
// IDLE  | no access in flight; pops the queue head when one is present
// WAIT  | latency countdown for the popped request
// RESP  | response presented, held until resp_ready
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [63:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            q_write_q [QDEPTH];
  logic [63:0]     q_addr_q  [QDEPTH];
  logic [63:0]     q_wdata_q [QDEPTH];

  logic            cur_write_q;
  logic [63:0]     cur_addr_q;
  logic [63:0]     cur_wdata_q;

  logic [63:0]     mem_q [DEPTH];

  logic            push, pop, mem_we, acc_err, oob;
  logic [AW-1:0]   idx;
  logic [63:0]     acc_rdata;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Full is decided on occupancy alone, so a same-cycle pop never frees a slot early.
  assign req_ready = (count_q != CW'(QDEPTH));
  assign push      = req_valid && req_ready;
  assign busy      = (count_q != '0) || (state_q != IDLE);

  assign idx = cur_addr_q[3 +: AW];

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
  assign oob = (cur_addr_q[63:3] >= 61'(DEPTH));
`else
  logic unused_addr_hi;
  assign oob            = 1'b0;
  assign unused_addr_hi = ^cur_addr_q[63:AW+3];
`endif

  assign acc_err   = (cur_addr_q[2:0] != 3'b000) || oob;
  assign acc_rdata = (acc_err || cur_write_q) ? 64'd0 : mem_q[idx];

  // Queue pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Queue pointers, occupancy and FSM registers; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Payload storage: queue slots and the request being served need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_write_q[wr_ptr_q] <= req_write;
      q_addr_q[wr_ptr_q]  <= req_addr;
      q_wdata_q[wr_ptr_q] <= req_wdata;
    end
    if (pop) begin
      cur_write_q <= q_write_q[rd_ptr_q];
      cur_addr_q  <= q_addr_q[rd_ptr_q];
      cur_wdata_q <= q_wdata_q[rd_ptr_q];
    end
  end

  // Backing array; deliberately unreset so committed stores survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= cur_wdata_q;
  end

  // Next-state, countdown and response capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    pop        = 1'b0;
    mem_we     = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          cnt_d   = 4'(LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          mem_we  = cur_write_q && !acc_err;
          rdata_d = acc_rdata;
          err_d   = acc_err;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a scoreboard of expected responses is filled at request
// acceptance from a word-memory model and drained by a response monitor.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err, busy;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] model [256];
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  function automatic exp_t model_access(input logic w, input logic [63:0] a, input logic [63:0] d);
    exp_t       e;
    logic       err;
    logic [7:0] idx;
    idx = a[10:3];
    err = (a[2:0] != 3'b000);
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    if (a[63:3] >= 61'd256) err = 1'b1;
`endif
    e.err   = err;
    e.rdata = 64'd0;
    if (!err) begin
      if (w) model[idx] = d;
      else   e.rdata = model[idx];
    end
    return e;
  endfunction

  // Response monitor: every handshake pops and checks the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL resp_unexpected: got rdata=%h err=%b, no response expected", resp_rdata, resp_err);
      end else begin
        mon_e = sb.pop_front();
        if (resp_rdata !== mon_e.rdata || resp_err !== mon_e.err) begin
          tests_failed++;
          $display("FAIL resp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                   resp_rdata, resp_err, mon_e.rdata, mon_e.err);
        end
      end
    end
  end

  task automatic send(input logic w, input logic [63:0] a, input logic [63:0] d,
                      input bit track, output int acc_cyc);
    bit done = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    acc_cyc = -1;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (req_ready) begin
        if (track) sb.push_back(model_access(w, a, d));
        @(posedge clk); #1;
        acc_cyc = cyc;
        done = 1;
      end
    end
    req_valid = 1'b0;
    if (!done) begin
      tests_run++; tests_failed++;
      $display("FAIL send_timeout: addr=%h never accepted", a);
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (!busy && !resp_valid && sb.size() == 0) done = 1;
    end
    if (!done) begin
      tests_run++; tests_failed++;
      $display("FAIL idle_timeout: busy=%b pending=%0d, expected idle with 0 pending", busy, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0 ||
        resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ready=%b valid=%b busy=%b rdata=%h err=%b, expected 1 0 0 0 0",
               req_ready, resp_valid, busy, resp_rdata, resp_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    int          acc, lat;
    logic        ws [2]  = '{1'b1, 1'b0};
    logic [63:0] ds [2]  = '{64'hDEADBEEF, 64'd0};
    resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(ws[i], 64'h10, ds[i], 1, acc);
      tests_run++;
      if (busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL busy_after_accept: got %b, expected 1", busy);
      end
      lat = -1;
      for (int k = 0; k < 30 && lat < 0; k++) begin
        @(negedge clk);
        if (resp_valid) lat = cyc - acc;
      end
      tests_run++;
      if (lat != 5) begin
        tests_failed++;
        $display("FAIL latency op%0d: got %0d cycles, expected 5", i, lat);
      end
      wait_idle();
    end
  endtask

  task automatic test_misaligned();
    int acc;
    resp_ready = 1'b1;
    send(1'b0, 64'h13, 64'd0, 1, acc);
    send(1'b1, 64'h15, 64'h999, 1, acc);
    send(1'b0, 64'h10, 64'd0, 1, acc);
    wait_idle();
  endtask

  task automatic test_bounds();
    int acc;
    resp_ready = 1'b1;
    send(1'b1, 64'h0,   64'hCAFE, 1, acc);
    send(1'b1, 64'h800, 64'h1234, 1, acc);
    send(1'b0, 64'h0,   64'd0,    1, acc);
    send(1'b1, 64'h7F8, 64'hF00D, 1, acc);
    send(1'b0, 64'h7F8, 64'd0,    1, acc);
    wait_idle();
    tests_run++;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    if (model[0] !== 64'hCAFE) begin
`else
    if (model[0] !== 64'h1234) begin
`endif
      tests_failed++;
      $display("FAIL bounds_model: word0=%h does not reflect the configured addressing mode", model[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic        ws [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] as [6] = '{64'h10, 64'h100, 64'h100, 64'h108, 64'h108, 64'h110};
    logic [63:0] ds [6] = '{64'd0, 64'h1111, 64'd0, 64'h2222, 64'd0, 64'h3333};
    logic        exp_rdy;
    logic [63:0] held;
    logic        held_err;
    bit          stable = 1;
    bit          seen = 0;
    resp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_write = ws[i]; req_addr = as[i]; req_wdata = ds[i];
      @(negedge clk);
      exp_rdy = (i < 5);
      tests_run++;
      if (req_ready !== exp_rdy) begin
        tests_failed++;
        $display("FAIL b2b_ready req%0d: got %b, expected %b", i, req_ready, exp_rdy);
      end
      if (exp_rdy) sb.push_back(model_access(ws[i], as[i], ds[i]));
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = resp_valid;
    end
    held = resp_rdata; held_err = resp_err;
    tests_run++;
    if (!seen || held !== 64'hDEADBEEF || held_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first_resp: valid=%b rdata=%h err=%b, expected 1 %h 0",
               seen, held, held_err, 64'hDEADBEEF);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== held || resp_err !== held_err || req_ready !== 1'b0)
        stable = 0;
    end
    tests_run++;
    if (!stable) begin
      tests_failed++;
      $display("FAIL b2b_stall_stable: valid=%b rdata=%h ready=%b, expected 1 %h 0",
               resp_valid, resp_rdata, req_ready, held);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int acc;
    bit ok = 1;
    resp_ready = 1'b1;
    send(1'b1, 64'h20, 64'h11, 1, acc);
    send(1'b1, 64'h30, 64'h77, 1, acc);
    wait_idle();
    send(1'b1, 64'h20, 64'hAA, 0, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) ok = 0;
      @(posedge clk); #1;
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL reset_mid: valid=%b busy=%b ready=%b, expected 0 0 1", resp_valid, busy, req_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 64'h20, 64'd0, 1, acc);
    send(1'b0, 64'h30, 64'd0, 1, acc);
    wait_idle();
  endtask

  task automatic test_raw();
    int acc1, acc2;
    resp_ready = 1'b1;
    send(1'b1, 64'h40, 64'h55, 1, acc1);
    send(1'b0, 64'h40, 64'd0,  1, acc2);
    tests_run++;
    if (acc2 != acc1 + 1) begin
      tests_failed++;
      $display("FAIL raw_consecutive: accepts at %0d and %0d, expected adjacent cycles", acc1, acc2);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_misaligned();
    test_bounds();
    test_back_to_back();
    test_reset_mid();
    test_raw();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DEPTH, 256, number of 64-bit words in backing storage; power of two.
- LATENCY, 4, access delay in cycles; legal range 1..15.
- QDEPTH, 4, request queue entries; power of two.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- req_valid, in, 1, request offered.
- req_ready, out, 1, queue can accept a request.
- req_write, in, 1, 1 = store, 0 = load.
- req_addr, in, 64, byte address.
- req_wdata, in, 64, store data.
- resp_valid, out, 1, response available.
- resp_ready, in, 1, consumer accepts the response.
- resp_rdata, out, 64, load data; 0 for stores and errors.
- resp_err, out, 1, misaligned or out-of-range access.
- busy, out, 1, queue non-empty or FSM not in IDLE.

Function
REQ-003 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1, and written into the in-order queue.
REQ-004 req_ready SHALL equal NOT queue-full.
REQ-005 There SHALL be no bypass: a request offered while the queue is full SHALL be ignored, even if a pop occurs in the same cycle.
REQ-006 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-007 In IDLE with the queue non-empty, the FSM SHALL pop the head, load counter = LATENCY, and go to WAIT.
REQ-008 In WAIT, the counter SHALL decrement each cycle.
REQ-009 In WAIT, on the edge where the counter equals 1, the block SHALL perform the access, register resp_rdata and resp_err, and go to RESP.
REQ-010 In RESP, resp_valid SHALL be 1.
REQ-011 In RESP, resp_rdata and resp_err SHALL hold stable until resp_valid and resp_ready are both 1, then the FSM SHALL return to IDLE.
REQ-012 resp_valid SHALL first be observed LATENCY+1 cycles after the acceptance edge when the FSM is idle and the queue is empty.
REQ-013 Word index SHALL be req_addr[3 +: log2(DEPTH)].
REQ-014 req_addr[2:0] != 0 SHALL set resp_err=1 and resp_rdata=0, with no array write.
REQ-015 A store SHALL write req_wdata into the array at the access edge and respond with resp_rdata=0 and resp_err=0.
REQ-016 A load SHALL return the array word as it was before that edge.
REQ-017 Responses SHALL be returned strictly in acceptance order, so a load after a store to the same address SHALL return the stored data.
REQ-018 busy SHALL be 1 whenever the queue is non-empty or the state is not IDLE.
REQ-019 Queue read and write pointers SHALL wrap modulo QDEPTH.
REQ-020 Full and empty SHALL be derived from an occupancy count of width log2(QDEPTH)+1.

Reset
REQ-021 While rst_n is 0, the queue SHALL be empty and the state SHALL be IDLE.
REQ-022 While rst_n is 0, resp_valid, resp_rdata, resp_err and busy SHALL be 0 and req_ready SHALL be 1.
REQ-023 Reset asserted mid-operation SHALL discard all queued and in-flight requests without writing the array.
REQ-024 Array contents SHALL NOT be reset; stores committed before reset SHALL persist.

Configuration
REQ-025 With MEM_RESPONDER_BOUNDS_CHECK_EN defined, req_addr[63:3] >= DEPTH SHALL set resp_err=1 and resp_rdata=0, with no array write.
REQ-026 Without MEM_RESPONDER_BOUNDS_CHECK_EN, upper address bits SHALL be ignored, so the index wraps modulo DEPTH, and only misalignment SHALL raise resp_err.

Verification
Defaults apply: LATENCY=4, DEPTH=256, QDEPTH=4.
REQ-027 Store 0x10 / 0xDEADBEEF, then load 0x10, with resp_ready=1.
- Response: store gives rdata 0, err 0; load gives rdata 0xDEADBEEF, err 0.
- Timing: each resp_valid rises 5 cycles after its own accept.
REQ-028 Load 0x13.
- Response: err 1, rdata 0, array unchanged.
REQ-029 Store 0x800 / 0x1234, then load 0x0.
- With the macro: store err 1, load returns the prior word-0 value.
- Without the macro: store err 0, load returns 0x1234.
REQ-030 Hold resp_ready=0 and offer 6 back-to-back requests.
- Expected: 1 request is popped into the FSM and 4 are queued; req_ready falls after the 5th accept.
- resp_rdata stays stable for 10 cycles of stall.
- Release resp_ready: 5 responses complete in order.
REQ-031 Assert rst_n=0 for 2 cycles while in WAIT for a store to 0x20 of 0xAA.
- Expected: resp_valid 0 and busy 0 during reset.
- A later load of 0x20 returns the pre-reset contents, not 0xAA.
- A load of an address stored before the reset returns its stored value.
REQ-032 Store 0x40 / 0x55, then immediately load 0x40 (consecutive accepts).
- Response: the load returns 0x55.
